// File: rtl/fc_seq_ctrl_if.sv
// FC engine link: serial weight load, input beats out, scores back.
interface fc_seq_ctrl_if #(
    parameter int DW = 32
);
    logic            fc_weight_en;
    logic            fc_weight;
    logic            fc_ivalid;
    logic [6*DW-1:0] fc_din;
    logic            fc_ovalid;
    logic [DW-1:0]   fc_dout;

    modport master (
        output fc_weight_en, fc_weight, fc_ivalid, fc_din,
        input  fc_ovalid, fc_dout
    );

    modport slave (
        input  fc_weight_en, fc_weight, fc_ivalid, fc_din,
        output fc_ovalid, fc_dout
    );
endinterface

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the binarized FC stage: weight load, beat feed, score
// collection with running arg-max, timeout and overflow reporting.
module fc_seq_ctrl #(
    parameter int N_WEIGHT = 192,
    parameter int N_BEAT   = 32,
    parameter int DW       = 32,
    parameter int N_OUT    = 10,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reload_w,
    output logic              w_rd,
    output logic [7:0]        w_addr,
    input  logic              w_rdata,
    output logic              f_rd,
    output logic [4:0]        f_addr,
    input  logic [6*DW-1:0]   f_rdata,
    fc_seq_ctrl_if.master     fc,
    output logic              res_valid,
    output logic [3:0]        res_idx,
    output logic [DW-1:0]     res_data,
    output logic [3:0]        max_idx,
    output logic [DW-1:0]     max_val,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_ovf
);
    localparam int FCW = $clog2(2*N_BEAT);
    localparam int TCW = $clog2(TIMEOUT+1);

    typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [8:0]      wcnt;
    logic            wen_q;
    logic [FCW-1:0]  fcnt;
    logic [3:0]      ocnt;
    logic [TCW-1:0]  idle_cnt;
    logic            weights_ok;
    logic [6*DW-1:0] din_hold;

    logic start_go, w_last, f_last, cnt_full, score_take, timeout_hit;

    assign start_go    = (state == S_IDLE) && start;
    assign w_last      = (wcnt == 9'(N_WEIGHT));
    assign f_last      = (fcnt == FCW'(2*N_BEAT-1));
    assign cnt_full    = (ocnt == 4'(N_OUT));
    assign score_take  = fc.fc_ovalid && !cnt_full &&
                         ((state == S_FEED) || (state == S_DRAIN));
    assign timeout_hit = (state == S_DRAIN) && !cnt_full && !fc.fc_ovalid &&
                         (idle_cnt == TCW'(TIMEOUT-1));

    // Read strobes and engine strobes decoded from state and phase counters
    always_comb begin
        w_rd            = (state == S_WLOAD) && !w_last;
        w_addr          = w_rd ? wcnt[7:0] : '0;
        f_rd            = (state == S_FEED) && !fcnt[0];
        f_addr          = f_rd ? 5'(fcnt >> 1) : '0;
        fc.fc_ivalid    = (state == S_FEED) && fcnt[0];
        fc.fc_din       = fc.fc_ivalid ? f_rdata : din_hold;
        fc.fc_weight_en = wen_q;
        fc.fc_weight    = wen_q & w_rdata;
        busy            = (state != S_IDLE);
        done            = (state == S_DONE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (reload_w || !weights_ok) ? S_WLOAD : S_FEED;
            S_WLOAD: if (w_last) state_nxt = S_FEED;
            S_FEED:  if (f_last) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (cnt_full)         state_nxt = S_DONE;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Weight address counter, one-cycle strobe delay and loaded flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt       <= '0;
            wen_q      <= 1'b0;
            weights_ok <= 1'b0;
        end else begin
            wcnt  <= (state == S_WLOAD) ? wcnt + 9'd1 : '0;
            wen_q <= w_rd;
            if ((state == S_WLOAD) && w_last) weights_ok <= 1'b1;
        end
    end

    // Feed phase counter: even cycles read, odd cycles present the beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt     <= '0;
            din_hold <= '0;
        end else begin
            fcnt <= (state == S_FEED) ? fcnt + 1'b1 : '0;
            if (fc.fc_ivalid) din_hold <= f_rdata;
        end
    end

    // Score forwarding, running arg-max (ties keep lower index)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
            ocnt      <= '0;
            max_idx   <= '0;
            max_val   <= '0;
        end else begin
            res_valid <= score_take;
            if (start_go) begin
                ocnt    <= '0;
                max_idx <= '0;
                max_val <= '0;
            end else if (score_take) begin
                res_idx  <= ocnt;
                res_data <= fc.fc_dout;
                ocnt     <= ocnt + 4'd1;
                if ((ocnt == '0) || ($signed(fc.fc_dout) > $signed(max_val))) begin
                    max_idx <= ocnt;
                    max_val <= fc.fc_dout;
                end
            end
        end
    end

    // Drain idle watchdog and sticky error flags (a set wins over start's clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            if ((state == S_DRAIN) && !fc.fc_ovalid) idle_cnt <= idle_cnt + 1'b1;
            else                                     idle_cnt <= '0;
            if (timeout_hit)   err_timeout <= 1'b1;
            else if (start_go) err_timeout <= 1'b0;
            if (fc.fc_ovalid && !score_take) err_ovf <= 1'b1;
            else if (start_go)               err_ovf <= 1'b0;
        end
    end
endmodule

// File: doc/fc_seq_ctrl.md
# fc_seq_ctrl

Sequencer for the binarized fully-connected stage. On `start` it streams the 192 serial weight bits from the weight ROM into the FC engine (`fc_weight`/`fc_weight_en`), then issues 32 input beats of six 32-bit lanes with the required one-cycle gap between `fc_ivalid` pulses. It then collects the engine's output scores, forwards them with an index, and reports the arg-max class. It sits between the conv-output feature buffer and weight ROM on one side and the FC engine on the other.

## Interface
- `N_WEIGHT`, 192: serial weight bits per load.
- `N_BEAT`, 32: input beats per inference (6 lanes each).
- `DW`, 32: signed data width per lane and per score.
- `N_OUT`, 10: scores expected from the FC engine per inference.
- `TIMEOUT`, 1024: max idle cycles in DRAIN before abort.
- `clk`  input  1  clock, all logic on rising edge.
- `rst`  input  1  asynchronous active-high reset.
- `start`  input  1  single-cycle request; honoured only in IDLE.
- `reload_w`  input  1  sampled with `start`; 1 forces a weight reload.
- `w_rd` / `w_addr`  output  1 / 8  weight ROM read; data returns next cycle.
- `w_rdata`  input  1  weight bit (already binarized, 1 = +1).
- `f_rd` / `f_addr`  output  1 / 5  feature buffer read; data returns next cycle.
- `f_rdata`  input  6*DW  lanes 0..5, lane 0 in LSBs.
- `fc_weight_en` / `fc_weight`  output  1 / 1  weight load strobe and bit.
- `fc_ivalid`  output  1  input beat strobe.
- `fc_din`  output  6*DW  lane data, valid with `fc_ivalid`.
- `fc_ovalid` / `fc_dout`  input  1 / DW  score strobe and signed score.
- `res_valid` / `res_idx` / `res_data`  output  1 / 4 / DW  forwarded score.
- `max_idx` / `max_val`  output  4 / DW  arg-max, stable from `done` until next `start`.
- `busy`  output  1  high outside IDLE.
- `done`  output  1  one-cycle pulse at end of inference.
- `err_timeout` / `err_ovf`  output  1 / 1  sticky errors, cleared by `start`.

## Operation
- States: IDLE, WLOAD, FEED, DRAIN, DONE.
- `weights_ok` flag: cleared by reset; set at WLOAD exit.
- IDLE + `start`: go to WLOAD if `reload_w` or !`weights_ok`, else FEED. `start` outside IDLE is ignored.
- WLOAD: `w_rd` is high with `w_addr` = 0..N_WEIGHT-1, one per cycle. `fc_weight_en` is high for exactly N_WEIGHT consecutive cycles, delayed one cycle from `w_rd`. `fc_weight` = `w_rdata`. Exit to FEED after the last strobe.
- FEED: beat b (0..N_BEAT-1) asserts `f_rd`, `f_addr` = b in FEED cycle 2b. In cycle 2b+1, `fc_ivalid` = 1 and `fc_din` = `f_rdata`. `fc_ivalid` is never high in two consecutive cycles. After beat N_BEAT-1, go to DRAIN.
- Score capture runs in FEED and DRAIN. Each `fc_ovalid` produces `res_valid` = 1 with `res_idx` = count and `res_data` = `fc_dout`, registered one cycle later; then the count increments.
- Arg-max: signed compare. The first score initialises it. A later score replaces it only if strictly greater, so ties keep the lower index.
- DRAIN: when the count reaches N_OUT, go to DONE. If `fc_ovalid` is absent for TIMEOUT consecutive cycles, set `err_timeout`, go to IDLE, and do not pulse `done`.
- DONE: `done` = 1 for one cycle, then IDLE.
- `fc_ovalid` after N_OUT scores, or while in IDLE/WLOAD/DONE: ignored and sets `err_ovf`.
- `fc_din` is held between beats. `fc_weight` = 0 when `fc_weight_en` = 0.

## Timing
- Reset: every output is 0 and the state is IDLE. Reset mid-operation aborts immediately and clears `weights_ok`, so the next `start` reloads weights.
- WLOAD is N_WEIGHT+1 cycles, FEED is 2*N_BEAT cycles and DONE is 1 cycle.
- Start to first `fc_weight_en` is 2 cycles. With default parameters, `start` to first `fc_ivalid` is 195 cycles with a load and 2 cycles without.
- Score to `res_valid` latency is 1 cycle. `done` asserts the cycle after the `res_valid` of the N_OUT-th score.
- `busy` rises the cycle after `start` and falls the cycle after `done`.

## Test plan
- Reset, then `start` with `reload_w` = 0: exactly 192 `fc_weight_en` cycles, with `fc_weight` matching ROM bits at addresses 0..191 in order. The first `fc_ivalid` comes 195 cycles after `start`.
- Feed buffer word b = {6 lanes of b*6+lane}: 32 `fc_ivalid` pulses, each followed by a low cycle, each carrying the matching word.
- Second `start` with `reload_w` = 0: no `fc_weight_en`, and the first `fc_ivalid` comes 2 cycles after `start`.
- Engine model returns scores {-5,3,7,-1,7,0,2,6,-9,1}: `res_idx` 0..9 with matching data, then `max_idx` = 2, `max_val` = 7, and one `done` pulse.
- Model returns only 9 scores: after 1024 idle cycles, `err_timeout` = 1, `busy` = 0 and no `done`. An 11th extra score instead sets `err_ovf`.
- Assert `rst` mid-FEED at beat 10: all outputs are 0 next cycle, and the following `start` performs a full weight load.
